// File: rtl/uart_rx_packet_ctrl.sv
// Packet framer behind a UART receiver: SYNC(0xA5), CMD, LEN, PAYLOAD[LEN], CHK.
// Validates length, XOR checksum and inter-byte timeout, then holds the packet until acked.
module uart_rx_packet_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned TIMEOUT_CLKS = 20 * CLKS_PER_BIT,
    parameter int unsigned MAX_LEN      = 16
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_Pkt_Ack,
    input  logic [3:0] i_Rd_Addr,
    output logic [7:0] o_Rd_Data,
    output logic       o_Pkt_Valid,
    output logic [7:0] o_Pkt_Cmd,
    output logic [4:0] o_Pkt_Len,
    output logic       o_Err_Chk,
    output logic       o_Err_Len,
    output logic       o_Err_Timeout,
    output logic       o_Err_Overrun,
    output logic       o_Busy
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0] SyncByte = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StGetCmd,
        StGetLen,
        StGetData,
        StGetChk,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [4:0]        len_q, len_d;
    logic [3:0]        idx_q, idx_d;
    logic [7:0]        chk_q, chk_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              err_chk_q, err_chk_d;
    logic              err_len_q, err_len_d;
    logic              err_tmo_q, err_tmo_d;
    logic              err_ovr_q, err_ovr_d;
    logic              buf_we;
    logic [7:0]        buf_q [MAX_LEN];
    logic              in_frame;

    assign in_frame = (state_q == StGetCmd) || (state_q == StGetLen) ||
                      (state_q == StGetData) || (state_q == StGetChk);

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        tmo_d     = '0;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_tmo_d = 1'b0;
        err_ovr_d = 1'b0;
        buf_we    = 1'b0;

        // A strobe on the expiry cycle wins, so expiry is only taken without DV.
        if (in_frame && !i_RX_DV) begin
            if (tmo_q == TmoW'(TIMEOUT_CLKS - 1)) begin
                err_tmo_d = 1'b1;
                state_d   = StIdle;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (i_RX_DV && i_RX_Byte == SyncByte) begin
                    state_d = StGetCmd;
                end
            end
            StGetCmd: begin
                if (i_RX_DV) begin
                    cmd_d   = i_RX_Byte;
                    chk_d   = i_RX_Byte;
                    state_d = StGetLen;
                end
            end
            StGetLen: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        len_d   = i_RX_Byte[4:0];
                        chk_d   = chk_q ^ i_RX_Byte;
                        idx_d   = '0;
                        state_d = (i_RX_Byte == 8'h00) ? StGetChk : StGetData;
                    end
                end
            end
            StGetData: begin
                if (i_RX_DV) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ i_RX_Byte;
                    idx_d  = idx_q + 1'b1;
                    if ({1'b0, idx_q} == len_q - 5'd1) begin
                        state_d = StGetChk;
                    end
                end
            end
            StGetChk: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte == chk_q) begin
                        state_d = StHold;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            StHold: begin
                if (i_Pkt_Ack) begin
                    // The coincident byte is judged as if already back in IDLE.
                    state_d = (i_RX_DV && i_RX_Byte == SyncByte) ? StGetCmd : StIdle;
                end else if (i_RX_DV) begin
                    err_ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            tmo_q     <= '0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            tmo_q     <= tmo_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            err_tmo_q <= err_tmo_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge i_Clock) begin
        if (buf_we && !i_Reset) begin
            buf_q[idx_q] <= i_RX_Byte;
        end
    end

    always_comb begin
        o_Pkt_Valid   = (state_q == StHold);
        o_Pkt_Cmd     = o_Pkt_Valid ? cmd_q : 8'h00;
        o_Pkt_Len     = o_Pkt_Valid ? len_q : 5'd0;
        o_Rd_Data     = (o_Pkt_Valid && ({1'b0, i_Rd_Addr} < len_q)) ? buf_q[i_Rd_Addr] : 8'h00;
        o_Err_Chk     = err_chk_q;
        o_Err_Len     = err_len_q;
        o_Err_Timeout = err_tmo_q;
        o_Err_Overrun = err_ovr_q;
        o_Busy        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Scoreboard bench for uart_rx_packet_ctrl: expected packets/errors are queued by the
// stimulus thread and popped by a monitor whenever the DUT presents a packet or error pulse.
`timescale 1ns/10ps
module tb_uart_rx_packet_ctrl;

    localparam int unsigned TimeoutClks = 4340;

    localparam int KPkt = 0;
    localparam int KChk = 1;
    localparam int KLen = 2;
    localparam int KTmo = 3;
    localparam int KOvr = 4;

    typedef struct packed {
        logic [2:0]       kind;
        logic [7:0]       cmd;
        logic [4:0]       len;
        logic [15:0][7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       ack = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       pkt_valid;
    logic [7:0] pkt_cmd;
    logic [4:0] pkt_len;
    logic       err_chk, err_len, err_tmo, err_ovr, busy;

    int   checks = 0;
    int   fails = 0;
    exp_t exp_q[$];

    uart_rx_packet_ctrl dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_RX_DV      (dv),
        .i_RX_Byte    (rx_byte),
        .i_Pkt_Ack    (ack),
        .i_Rd_Addr    (rd_addr),
        .o_Rd_Data    (rd_data),
        .o_Pkt_Valid  (pkt_valid),
        .o_Pkt_Cmd    (pkt_cmd),
        .o_Pkt_Len    (pkt_len),
        .o_Err_Chk    (err_chk),
        .o_Err_Len    (err_len),
        .o_Err_Timeout(err_tmo),
        .o_Err_Overrun(err_ovr),
        .o_Busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input logic [7:0] cmd, input logic [4:0] len,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        exp_t e;
        e = '0;
        e.kind = 3'(KPkt);
        e.cmd = cmd;
        e.len = len;
        e.data[0] = d0;
        e.data[1] = d1;
        e.data[2] = d2;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input int kind);
        exp_t e;
        e = '0;
        e.kind = 3'(kind);
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        dv = 1'b1;
        rx_byte = b;
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack_valid_drop", 32'(pkt_valid), 32'd0);
        check("ack_busy_idle", 32'(busy), 32'd0);
        check("ack_rd_zero", 32'(rd_data), 32'd0);
    endtask

    task automatic check_payload(input exp_t e, input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #0.1;
            if (i < int'(e.len)) check({tag, "_rd"}, 32'(rd_data), 32'(e.data[i]));
            else if (i == int'(e.len) || i == 15) check({tag, "_rd_oob"}, 32'(rd_data), 32'd0);
        end
        rd_addr = 4'd0;
    endtask

    task automatic monitor();
        logic       pv = 1'b0;
        logic [3:0] pe = 4'd0;
        logic [3:0] errs;
        int         act_kind;
        exp_t       e, last;
        last = '0;
        forever begin
            @(negedge clk);
            errs = {err_chk, err_len, err_tmo, err_ovr};
            if (pkt_valid && !pv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pkt", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pkt_kind", 32'(KPkt), 32'(e.kind));
                    check("pkt_cmd", 32'(pkt_cmd), 32'(e.cmd));
                    check("pkt_len", 32'(pkt_len), 32'(e.len));
                    check_payload(e, "pkt");
                    last = e;
                end
            end
            if (errs != 4'd0) begin
                check("err_onehot", 32'($countones(errs)), 32'd1);
                check("err_width", 32'(pe), 32'd0);
                act_kind = err_chk ? KChk : err_len ? KLen : err_tmo ? KTmo : KOvr;
                if (exp_q.size() == 0) begin
                    check("unexpected_err", 32'(act_kind), 32'hFF);
                end else begin
                    e = exp_q.pop_front();
                    check("err_kind", 32'(act_kind), 32'(e.kind));
                end
                if (err_ovr && pkt_valid) check_payload(last, "ovr");
            end
            pv = pkt_valid;
            pe = errs;
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd", 32'(pkt_cmd), 32'd0);
        check("rst_len", 32'(pkt_len), 32'd0);
        check("rst_errs", 32'({err_chk, err_len, err_tmo, err_ovr}), 32'd0);
        rst = 1'b0;

        // 1: basic two-byte packet; a leading junk byte is ignored
        send_byte(8'h3C);
        check("idle_junk_busy", 32'(busy), 32'd0);
        push_pkt(8'h10, 5'd2, 8'h11, 8'h22, 8'h00);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        check("t1_pre_valid", 32'(pkt_valid), 32'd0);
        send_byte(8'h21);
        check("t1_valid", 32'(pkt_valid), 32'd1);
        check("t1_cmd", 32'(pkt_cmd), 32'h10);
        do_ack();

        // 2: zero-length packet, then checksum error
        push_pkt(8'h07, 5'd0, 8'h00, 8'h00, 8'h00);
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
        check("t2_valid", 32'(pkt_valid), 32'd1);
        check("t2_len", 32'(pkt_len), 32'd0);
        do_ack();
        push_err(KChk);
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h08);
        check("t2_err_chk", 32'(err_chk), 32'd1);
        check("t2_no_valid", 32'(pkt_valid), 32'd0);
        @(negedge clk);
        check("t2_err_chk_end", 32'(err_chk), 32'd0);

        // 3: length error, then a good frame
        push_err(KLen);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11);
        check("t3_err_len", 32'(err_len), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        push_pkt(8'h02, 5'd1, 8'h99, 8'h00, 8'h00);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h99);
        send_byte(8'h9A);
        check("t3_valid", 32'(pkt_valid), 32'd1);
        do_ack();

        // 4: timeout exactly TimeoutClks cycles after the last strobe
        push_err(KTmo);
        send_byte(8'hA5); send_byte(8'h01);
        repeat (TimeoutClks - 1) @(negedge clk);
        check("t4_tmo_early", 32'(err_tmo), 32'd0);
        check("t4_busy_early", 32'(busy), 32'd1);
        @(negedge clk);
        check("t4_tmo", 32'(err_tmo), 32'd1);
        check("t4_tmo_idle", 32'(busy), 32'd0);
        // Strobe on the expiry cycle beats the timeout
        push_pkt(8'h01, 5'd2, 8'h33, 8'h44, 8'h00);
        send_byte(8'hA5); send_byte(8'h01);
        repeat (TimeoutClks - 1) @(negedge clk);
        dv = 1'b1;
        rx_byte = 8'h02;
        @(negedge clk);
        dv = 1'b0;
        check("t4_dv_wins", 32'(err_tmo), 32'd0);
        check("t4_dv_busy", 32'(busy), 32'd1);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h74);
        check("t4_valid", 32'(pkt_valid), 32'd1);
        do_ack();

        // 5: overrun while held, then ack coincident with a sync byte
        push_pkt(8'h20, 5'd1, 8'h5A, 8'h00, 8'h00);
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h01); send_byte(8'h5A);
        send_byte(8'h7B);
        push_err(KOvr);
        send_byte(8'h55);
        check("t5_ovr", 32'(err_ovr), 32'd1);
        check("t5_valid_kept", 32'(pkt_valid), 32'd1);
        check("t5_cmd_kept", 32'(pkt_cmd), 32'h20);
        check("t5_len_kept", 32'(pkt_len), 32'd1);
        @(negedge clk);
        dv = 1'b1;
        rx_byte = 8'hA5;
        ack = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        ack = 1'b0;
        check("t5_ack_valid", 32'(pkt_valid), 32'd0);
        check("t5_ack_busy", 32'(busy), 32'd1);
        check("t5_no_ovr", 32'(err_ovr), 32'd0);

        // 6: reset in GET_DATA, then a frame containing 0xA5 as data
        send_byte(8'h30); send_byte(8'h03); send_byte(8'h01);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_valid", 32'(pkt_valid), 32'd0);
        check("t6_rst_cmdlen", 32'({pkt_cmd, 3'b000, pkt_len}), 32'd0);
        check("t6_rst_errs", 32'({err_chk, err_len, err_tmo, err_ovr}), 32'd0);
        rst = 1'b0;
        push_pkt(8'h40, 5'd3, 8'hA5, 8'h01, 8'h02);
        send_byte(8'hA5); send_byte(8'h40); send_byte(8'h03);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'hE5);
        check("t6_valid", 32'(pkt_valid), 32'd1);
        check("t6_cmd", 32'(pkt_cmd), 32'h40);
        do_ack();

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
